// File: rtl/cam_ctrl.sv
// CAM controller: sequences READ / WRITE / SEARCH / WRITE_FREE commands onto an external CAM array.
// Optional free-slot allocation for WRITE_FREE is enabled by defining CAM_CTRL_WRITE_FREE_EN.
module cam_ctrl #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [ADDR_WIDTH-1:0]    cmd_addr,
   input  logic [WIDTH-1:0]         cmd_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ADDR_WIDTH-1:0]    rsp_index,
   output logic                     rsp_hit,
   output logic                     rsp_err,
   output logic [DEPTH-1:0]         write_enable_o,
   output logic [DEPTH-1:0]         read_enable_o,
   output logic                     search_enable_o,
   output logic [WIDTH-1:0]         write_data_o,
   output logic [WIDTH-1:0]         search_data_o,
   input  logic [DEPTH*WIDTH-1:0]   all_data_i,
   input  logic [DEPTH-1:0]         search_result_i,
   input  logic [DEPTH-1:0]         read_valid_i,
   output logic                     full_o
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_SEARCH = 2'b10;
   localparam logic [1:0] OP_WFREE  = 2'b11;

   if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $error("cam_ctrl: DEPTH must equal 2**ADDR_WIDTH");
   end

   logic [1:0]            state, state_nxt;
   logic [1:0]            op_q, op_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [WIDTH-1:0]      data_q, data_nxt;
   logic                  refuse_q, refuse_nxt;
   logic [DEPTH-1:0]      occ, occ_nxt;

   logic                  cmd_ready_nxt, rsp_valid_nxt, rsp_hit_nxt, rsp_err_nxt;
   logic [WIDTH-1:0]      rsp_data_nxt, write_data_nxt, search_data_nxt;
   logic [ADDR_WIDTH-1:0] rsp_index_nxt;
   logic [DEPTH-1:0]      we_nxt, re_nxt;
   logic                  se_nxt;

   logic [DEPTH-1:0]      match;
   logic [ADDR_WIDTH-1:0] hit_idx;

   // Lowest occupied word whose array match flag is set.
   always_comb begin
      match   = search_result_i & occ;
      hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match[i]) hit_idx = ADDR_WIDTH'(i);
      end
   end

`ifdef CAM_CTRL_WRITE_FREE_EN
   logic [ADDR_WIDTH-1:0] free_idx;

   // Lowest unoccupied word, the allocation target for WRITE_FREE.
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!occ[i]) free_idx = ADDR_WIDTH'(i);
      end
   end
`endif

   always_comb begin
      state_nxt       = state;
      op_nxt          = op_q;
      addr_nxt        = addr_q;
      data_nxt        = data_q;
      refuse_nxt      = refuse_q;
      occ_nxt         = occ;
      rsp_valid_nxt   = rsp_valid;
      rsp_data_nxt    = rsp_data;
      rsp_index_nxt   = rsp_index;
      rsp_hit_nxt     = rsp_hit;
      rsp_err_nxt     = rsp_err;
      write_data_nxt  = write_data_o;
      search_data_nxt = search_data_o;
      we_nxt          = '0;
      re_nxt          = '0;
      se_nxt          = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_nxt  = ISSUE;
               op_nxt     = cmd_op;
               addr_nxt   = cmd_addr;
               data_nxt   = cmd_data;
               refuse_nxt = 1'b0;
               case (cmd_op)
                  OP_READ:   re_nxt = DEPTH'(1) << cmd_addr;
                  OP_WRITE: begin
                     we_nxt         = DEPTH'(1) << cmd_addr;
                     write_data_nxt = cmd_data;
                  end
                  OP_SEARCH: begin
                     se_nxt          = 1'b1;
                     search_data_nxt = cmd_data;
                  end
                  default: begin
`ifdef CAM_CTRL_WRITE_FREE_EN
                     if (&occ) begin
                        refuse_nxt = 1'b1;
                     end else begin
                        addr_nxt       = free_idx;
                        we_nxt         = DEPTH'(1) << free_idx;
                        write_data_nxt = cmd_data;
                     end
`else
                     refuse_nxt = 1'b1;
`endif
                  end
               endcase
            end
         end
         ISSUE: begin
            state_nxt = CAPTURE;
            re_nxt    = read_enable_o;
            se_nxt    = search_enable_o;
            if (op_q == OP_WRITE || (op_q == OP_WFREE && !refuse_q)) occ_nxt[addr_q] = 1'b1;
         end
         CAPTURE: begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = data_q;
            rsp_index_nxt = addr_q;
            rsp_hit_nxt   = 1'b0;
            rsp_err_nxt   = 1'b0;
            case (op_q)
               OP_READ: begin
                  rsp_data_nxt = all_data_i[WIDTH*addr_q +: WIDTH];
                  rsp_err_nxt  = !read_valid_i[addr_q] || !occ[addr_q];
               end
               OP_SEARCH: begin
                  rsp_hit_nxt   = |match;
                  rsp_index_nxt = hit_idx;
               end
               OP_WFREE: begin
                  rsp_err_nxt = refuse_q;
                  if (refuse_q) rsp_index_nxt = '0;
               end
               default: ;
            endcase
         end
         default: begin
            if (rsp_valid && rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
            end
         end
      endcase

      cmd_ready_nxt = (state_nxt == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         op_q            <= OP_READ;
         addr_q          <= '0;
         data_q          <= '0;
         refuse_q        <= 1'b0;
         occ             <= '0;
         cmd_ready       <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_data        <= '0;
         rsp_index       <= '0;
         rsp_hit         <= 1'b0;
         rsp_err         <= 1'b0;
         write_enable_o  <= '0;
         read_enable_o   <= '0;
         search_enable_o <= 1'b0;
         write_data_o    <= '0;
         search_data_o   <= '0;
      end else begin
         state           <= state_nxt;
         op_q            <= op_nxt;
         addr_q          <= addr_nxt;
         data_q          <= data_nxt;
         refuse_q        <= refuse_nxt;
         occ             <= occ_nxt;
         cmd_ready       <= cmd_ready_nxt;
         rsp_valid       <= rsp_valid_nxt;
         rsp_data        <= rsp_data_nxt;
         rsp_index       <= rsp_index_nxt;
         rsp_hit         <= rsp_hit_nxt;
         rsp_err         <= rsp_err_nxt;
         write_enable_o  <= we_nxt;
         read_enable_o   <= re_nxt;
         search_enable_o <= se_nxt;
         write_data_o    <= write_data_nxt;
         search_data_o   <= search_data_nxt;
      end
   end

`ifdef CAM_CTRL_WRITE_FREE_EN
   // Tracks occupancy on the same edge that occ changes.
   always_ff @(posedge clk) begin
      if (reset) full_o <= 1'b0;
      else       full_o <= &occ_nxt;
   end
`else
   assign full_o = 1'b0;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: behavioural CAM array plus an occupancy/contents reference model.
module tb_cam_ctrl;
   localparam int unsigned W  = 32;
   localparam int unsigned D  = 32;
   localparam int unsigned AW = 5;

   localparam logic [1:0] RD = 2'b00, WR = 2'b01, SR = 2'b10, WF = 2'b11;

   logic              clk, reset;
   logic              cmd_valid, cmd_ready;
   logic [1:0]        cmd_op;
   logic [AW-1:0]     cmd_addr;
   logic [W-1:0]      cmd_data;
   logic              rsp_valid, rsp_ready;
   logic [W-1:0]      rsp_data;
   logic [AW-1:0]     rsp_index;
   logic              rsp_hit, rsp_err;
   logic [D-1:0]      write_enable_o, read_enable_o;
   logic              search_enable_o;
   logic [W-1:0]      write_data_o, search_data_o;
   logic [D*W-1:0]    all_data_i;
   logic [D-1:0]      search_result_i, read_valid_i;
   logic              full_o;

   int checks = 0;
   int errors = 0;

   cam_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_index(rsp_index), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
      .write_enable_o(write_enable_o), .read_enable_o(read_enable_o),
      .search_enable_o(search_enable_o), .write_data_o(write_data_o),
      .search_data_o(search_data_o), .all_data_i(all_data_i),
      .search_result_i(search_result_i), .read_valid_i(read_valid_i),
      .full_o(full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural CAM array driven by the controller's enables.
   logic [W-1:0]  mem [D];
   logic [D-1:0]  arr_valid;
   logic          env_clr, poke_en;
   logic [AW-1:0] poke_idx;
   logic [W-1:0]  poke_val;

   always @(posedge clk) begin
      if (env_clr) begin
         for (int k = 0; k < D; k++) mem[k] <= '0;
         arr_valid <= '0;
      end else begin
         for (int k = 0; k < D; k++) begin
            if (write_enable_o[k]) begin
               mem[k]       <= write_data_o;
               arr_valid[k] <= 1'b1;
            end
         end
         if (poke_en) mem[poke_idx] <= poke_val;
      end
   end

   always_comb begin
      all_data_i      = '0;
      search_result_i = '0;
      for (int k = 0; k < D; k++) begin
         all_data_i[k*W +: W] = mem[k];
         search_result_i[k]   = search_enable_o && (mem[k] == search_data_o);
      end
   end
   assign read_valid_i = arr_valid;

   // Reference model: what the array holds and which words the controller owns.
   logic [W-1:0] ref_mem [D];
   logic [D-1:0] ref_occ, ref_rv;

   typedef struct {
      logic [W-1:0]  data;
      logic [AW-1:0] idx;
      logic          hit, err, refused, full, se;
      logic [D-1:0]  we, re;
   } exp_t;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      check("onehot_word_enables", 64'(($countones(write_enable_o) + $countones(read_enable_o)) <= 1), 64'd1);

   task automatic predict(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] data,
                          output exp_t e);
      int slot;
      e = '{data: data, idx: addr, hit: 1'b0, err: 1'b0, refused: 1'b0, full: 1'b0, se: 1'b0,
            we: '0, re: '0};
      slot = -1;
      case (op)
         RD: begin
            e.data = ref_mem[addr];
            e.err  = !(ref_rv[addr] && ref_occ[addr]);
            e.re   = D'(1) << addr;
         end
         WR: slot = int'(addr);
         SR: begin
            e.se  = 1'b1;
            e.idx = '0;
            for (int k = 0; k < D; k++) begin
               if (!e.hit && ref_occ[k] && ref_mem[k] == data) begin
                  e.hit = 1'b1;
                  e.idx = AW'(k);
               end
            end
         end
         default: begin
`ifdef CAM_CTRL_WRITE_FREE_EN
            for (int k = D - 1; k >= 0; k--) if (!ref_occ[k]) slot = k;
`endif
            if (slot < 0) begin
               e.err     = 1'b1;
               e.refused = 1'b1;
            end
         end
      endcase
      if (slot >= 0) begin
         e.idx         = AW'(slot);
         e.we          = D'(1) << slot;
         ref_mem[slot] = data;
         ref_rv[slot]  = 1'b1;
         ref_occ[slot] = 1'b1;
      end
`ifdef CAM_CTRL_WRITE_FREE_EN
      e.full = &ref_occ;
`endif
   endtask

   task automatic check_rsp(input exp_t e);
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
      check("rsp_err", 64'(rsp_err), 64'(e.err));
      if (!e.refused) begin
         check("rsp_data", 64'(rsp_data), 64'(e.data));
         check("rsp_index", 64'(rsp_index), 64'(e.idx));
      end
      check("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
   endtask

   // Returns 1 once the command has been accepted, 0 on timeout.
   task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] data,
                       output exp_t e, output bit ok);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; rsp_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", 64'd0, 64'd1);
         cmd_valid = 1'b0;
         e = '{default: '0};
         return;
      end
      predict(op, addr, data, e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] data,
                         input int hold);
      exp_t e;
      bit   ok;
      send(op, addr, data, e, ok);
      if (!ok) return;
      @(negedge clk);
      check("issue_we", 64'(write_enable_o), 64'(e.we));
      check("issue_re", 64'(read_enable_o), 64'(e.re));
      check("issue_se", 64'(search_enable_o), 64'(e.se));
      if (e.we != '0) check("issue_wdata", 64'(write_data_o), 64'(data));
      if (e.se) check("issue_key", 64'(search_data_o), 64'(data));
      check("issue_busy", 64'({cmd_ready, rsp_valid}), 64'd0);
      @(negedge clk);
      check("cap_we", 64'(write_enable_o), 64'd0);
      check("cap_re", 64'(read_enable_o), 64'(e.re));
      check("cap_se", 64'(search_enable_o), 64'(e.se));
      check("cap_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("resp_enables", 64'({write_enable_o | read_enable_o, search_enable_o}), 64'd0);
      check("resp_full", 64'(full_o), 64'(e.full));
      check_rsp(e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_rsp(e);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("done_rsp_valid", 64'(rsp_valid), 64'd0);
      check("done_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      check("rst_ctrl", 64'({cmd_ready, rsp_valid, rsp_hit, rsp_err, search_enable_o, full_o}), 64'd0);
      check("rst_enables", 64'(write_enable_o | read_enable_o), 64'd0);
      check("rst_rsp", 64'({rsp_data, rsp_index}), 64'd0);
      check("rst_buses", 64'({write_data_o, search_data_o}), 64'd0);
      reset = 1'b0;
      ref_occ = '0;
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   task automatic poke(input logic [AW-1:0] idx, input logic [W-1:0] val);
      @(negedge clk);
      poke_en = 1'b1; poke_idx = idx; poke_val = val;
      @(negedge clk);
      poke_en = 1'b0;
      ref_mem[idx] = val;
   endtask

   // Reset in the given phase (1 = ISSUE, 2 = CAPTURE) of a command: no response may follow.
   task automatic reset_during(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] data,
                               input int phase);
      exp_t e;
      bit   ok;
      send(op, addr, data, e, ok);
      if (!ok) return;
      for (int p = 0; p < phase; p++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_enables", 64'({write_enable_o | read_enable_o, search_enable_o}), 64'd0);
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      reset = 1'b0;
      ref_occ = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_rsp", 64'(rsp_valid), 64'd0);
      end
      check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      logic [W-1:0] pool [4];
      reset = 1'b1; env_clr = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
      cmd_valid = 1'b0; cmd_op = RD; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
      for (int k = 0; k < D; k++) ref_mem[k] = '0;
      ref_rv = '0; ref_occ = '0;
      repeat (2) @(posedge clk);
      do_reset();
      env_clr = 1'b0;

      do_cmd(RD, 5'd0, 32'h0, 0);
      do_cmd(WR, 5'd0, 32'hF0F0_F0F0, 0);
      do_cmd(SR, 5'd0, 32'hF0F0_F0F0, 1);
      do_cmd(RD, 5'd0, 32'h0, 0);
      do_cmd(WR, 5'd31, 32'h8000_0000, 0);
      do_cmd(WR, 5'd5, 32'h8000_0000, 0);
      do_cmd(SR, 5'd0, 32'h8000_0000, 0);
      do_cmd(SR, 5'd0, 32'h1234_5678, 0);
      do_cmd(RD, 5'd5, 32'h0, 4);

      // Stale array contents in an unowned word must neither hit nor read clean.
      poke(5'd7, 32'hDEAD_BEEF);
      do_cmd(SR, 5'd0, 32'hDEAD_BEEF, 0);
      do_cmd(RD, 5'd7, 32'h0, 0);

      reset_during(SR, 5'd0, 32'h8000_0000, 2);
      do_cmd(SR, 5'd0, 32'h8000_0000, 0);
      do_cmd(RD, 5'd5, 32'h0, 0);

      // Array still takes the one-cycle write pulse; ownership is not recorded.
      ref_mem[9] = 32'h0BAD_CAFE; ref_rv[9] = 1'b1;
      reset_during(WR, 5'd9, 32'h0BAD_CAFE, 1);
      do_cmd(RD, 5'd9, 32'h0, 0);

      do_reset();
`ifdef CAM_CTRL_WRITE_FREE_EN
      for (int i = 0; i < 33; i++) do_cmd(WF, 5'd0, 32'(i) ^ 32'hA500_0000, 0);
      check("wfree_full", 64'(full_o), 64'd1);
`else
      do_cmd(WF, 5'd0, 32'h1111_1111, 0);
`endif

      do_reset();
      pool[0] = 32'hA5A5_A5A5; pool[1] = 32'h0; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h0000_00C3;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0)
            poke(AW'($urandom_range(0, D - 1)), pool[$urandom_range(0, 3)]);
         do_cmd(2'($urandom_range(0, 3)), AW'($urandom_range(0, D - 1)),
                ($urandom_range(0, 4) == 4) ? 32'($urandom) : pool[$urandom_range(0, 3)],
                $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: bits per CAM word.
REQ-002 Parameter DEPTH, default 32: number of eff words in the array.
REQ-003 Parameter ADDR_WIDTH, default 5: index width; the design SHALL require DEPTH == 2**ADDR_WIDTH.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-007 cmd_op  in  2  opcode: 00 READ, 01 WRITE, 10 SEARCH, 11 WRITE_FREE.
REQ-008 cmd_addr  in  ADDR_WIDTH  target word for READ and WRITE.
REQ-009 cmd_data  in  WIDTH  write data or search key.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_data  out  WIDTH  read data, or the written data for WRITE and WRITE_FREE.
REQ-012 rsp_index  out  ADDR_WIDTH  matched, written or read index.
REQ-013 rsp_hit  out  1  SEARCH matched at least one valid word.
REQ-014 rsp_err  out  1  READ of a non-valid word, or WRITE_FREE refused.
REQ-015 write_enable_o / read_enable_o  out  DEPTH  one-hot per-word enables to the array.
REQ-016 search_enable_o  out  1  broadcast search enable.
REQ-017 write_data_o / search_data_o  out  WIDTH  array data buses.
REQ-018 all_data_i  in  DEPTH*WIDTH  word k on bits [WIDTH*(k+1)-1 : WIDTH*k].
REQ-019 search_result_i / read_valid_i  in  DEPTH  per-word match and read-valid flags.
REQ-020 full_o  out  1  all DEPTH occupancy bits are set.

Function
REQ-021 FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; no other states.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready, and the op, addr and data are registered at that edge.
REQ-023 In ISSUE, a WRITE SHALL assert write_enable_o[addr] for exactly one cycle, with write_data_o = the registered data.
REQ-024 For READ, read_enable_o[addr] SHALL be held through ISSUE and CAPTURE; for SEARCH, search_enable_o SHALL be held through ISSUE and CAPTURE, with search_data_o = the key.
REQ-025 Array outputs SHALL be sampled at the end of CAPTURE; rsp_valid SHALL rise 3 cycles after accept.
REQ-026 rsp_* SHALL be held stable while rsp_valid && !rsp_ready; the FSM returns to IDLE on the rsp_valid && rsp_ready edge.
REQ-027 READ: rsp_data = word addr, rsp_index = addr, rsp_err = !read_valid_i[addr] || !occ[addr].
REQ-028 SEARCH: the match vector is search_result_i & occ; rsp_hit = OR of the vector; rsp_index = lowest set bit, or 0 when there is no hit; rsp_data = key.
REQ-029 WRITE SHALL set occ[addr] at the ISSUE edge; rsp_index = addr, rsp_hit = 0, rsp_err = 0.
REQ-030 All enables SHALL be 0 in IDLE, CAPTURE (for writes) and RESP; at most one word enable SHALL be active at any time.
REQ-031 full_o SHALL equal the AND of occ, registered.

Reset
REQ-032 reset SHALL force IDLE, clear occ, and force all outputs to 0, except cmd_ready = 1 in the cycle after reset deasserts.
REQ-033 reset mid-operation SHALL abort the operation without issuing a response; enables drop in the first reset cycle, and a write pending in ISSUE at that edge is discarded.

Configuration
REQ-034 With CAM_CTRL_WRITE_FREE_EN defined, WRITE_FREE SHALL write to the lowest index with occ = 0, set that occ bit and return rsp_index = that index; when full_o = 1 it SHALL assert no enables and respond rsp_err = 1.
REQ-035 Without CAM_CTRL_WRITE_FREE_EN, WRITE_FREE SHALL assert no enables and respond rsp_err = 1 after the same 3-cycle latency, and full_o SHALL be tied to 0.

Verification
REQ-036 After reset: READ addr 0 -> rsp_err = 1, rsp_data = 0, rsp_valid rises 3 cycles after accept.
REQ-037 WRITE addr 0 data F0F0F0F0, then SEARCH F0F0F0F0 -> rsp_hit = 1, rsp_index = 0; a following READ addr 0 -> rsp_data = F0F0F0F0, rsp_err = 0.
REQ-038 WRITE 80000000 to addr 31 and addr 5, SEARCH 80000000 -> rsp_hit = 1, rsp_index = 5; SEARCH 12345678 -> rsp_hit = 0, rsp_index = 0.
REQ-039 Hold rsp_ready = 0 for 4 cycles during a READ -> rsp_* stable, cmd_ready = 0 throughout, and the next command is accepted only after the handshake.
REQ-040 With the macro: 32 x WRITE_FREE -> indices 0..31 in order and full_o = 1; a 33rd -> rsp_err = 1 with no enables. Without the macro: rsp_err = 1 on the first WRITE_FREE.
REQ-041 Assert reset in CAPTURE of a SEARCH -> no rsp_valid, enables 0 next cycle, and occ cleared (a subsequent SEARCH misses).
